// File: rtl/redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : redirect_ctrl
// Description : Arbitrates write/execute stage redirects, presents them to
//               fetch with a valid/ready handshake, pulses pipeline flushes,
//               tracks in-flight fetch requests and drops stale responses.
//               Optional macro REDIRECT_STATS_EN adds an accepted-redirect
//               counter on redirect_cnt (constant 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module redirect_ctrl #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_jmp_en,
    input  logic [31:0] wr_jmp_pc,
    input  logic        ex_jmp_en,
    input  logic [31:0] ex_jmp_pc,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready,
    input  logic        fetch_req_fire,
    input  logic        fetch_resp_fire,
    output logic        fetch_hold,
    output logic        discard_resp,
    output logic        flush_if,
    output logic        flush_id,
    output logic        flush_ex,
    output logic [31:0] redirect_cnt
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             redir_valid_q, redir_valid_d;
    logic [31:0]      redir_pc_q, redir_pc_d;
    logic             flush_if_q, flush_if_d;
    logic             flush_id_q, flush_id_d;
    logic             flush_ex_q, flush_ex_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic             handshake;
    logic             new_req;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] discard_load;

    assign handshake    = redir_valid_q && redir_ready;
    assign new_req      = wr_jmp_en || ex_jmp_en;
    // The write stage always wins; a simultaneous execute request is dropped.
    assign new_pc       = wr_jmp_en ? wr_jmp_pc : ex_jmp_pc;
    // A response arriving on the handshake cycle is already counted out of
    // inflight, so it must not be counted again as stale.
    assign discard_load = (fetch_resp_fire && (inflight_q != '0)) ? (inflight_q - C_ONE) : inflight_q;

    assign discard_resp = fetch_resp_fire && (discard_q != '0);
    assign fetch_hold   = (state_q != IDLE);
    assign redir_valid  = redir_valid_q;
    assign redir_pc     = redir_pc_q;
    assign flush_if     = flush_if_q;
    assign flush_id     = flush_id_q;
    assign flush_ex     = flush_ex_q;

    // Saturating count of outstanding fetch requests.
    always_comb begin
        inflight_d = inflight_q;
        if (fetch_req_fire && !fetch_resp_fire && (inflight_q != C_MAX)) begin
            inflight_d = inflight_q + C_ONE;
        end else if (fetch_resp_fire && !fetch_req_fire && (inflight_q != '0)) begin
            inflight_d = inflight_q - C_ONE;
        end
    end

    // Next-state, redirect payload, flush pulses and discard counter.
    always_comb begin
        state_d       = state_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        flush_if_d    = 1'b0;
        flush_id_d    = 1'b0;
        flush_ex_d    = 1'b0;
        discard_d     = discard_resp ? (discard_q - C_ONE) : discard_q;
        case (state_q)
            IDLE: begin
                if (new_req) begin
                    state_d       = HOLD;
                    redir_valid_d = 1'b1;
                    redir_pc_d    = new_pc;
                    flush_if_d    = 1'b1;
                    flush_id_d    = 1'b1;
                    flush_ex_d    = wr_jmp_en;
                end
            end
            HOLD: begin
                if (handshake) begin
                    redir_valid_d = 1'b0;
                    discard_d     = discard_load;
                    state_d       = (discard_load != '0) ? DRAIN : IDLE;
                    // A write-stage redirect on the handshake cycle is
                    // presented immediately as a fresh redirect.
                    if (wr_jmp_en) begin
                        state_d       = HOLD;
                        redir_valid_d = 1'b1;
                        redir_pc_d    = wr_jmp_pc;
                        flush_if_d    = 1'b1;
                        flush_id_d    = 1'b1;
                        flush_ex_d    = 1'b1;
                    end
                end else if (wr_jmp_en) begin
                    // Execute-stage requests are younger than the pending
                    // redirect and are ignored; write-stage ones replace it.
                    redir_pc_d = wr_jmp_pc;
                    flush_if_d = 1'b1;
                    flush_id_d = 1'b1;
                    flush_ex_d = 1'b1;
                end
            end
            DRAIN: begin
                if (new_req) begin
                    state_d       = HOLD;
                    redir_valid_d = 1'b1;
                    redir_pc_d    = new_pc;
                    flush_if_d    = 1'b1;
                    flush_id_d    = 1'b1;
                    flush_ex_d    = wr_jmp_en;
                end else if (discard_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
            flush_if_q    <= 1'b0;
            flush_id_q    <= 1'b0;
            flush_ex_q    <= 1'b0;
            inflight_q    <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            flush_if_q    <= flush_if_d;
            flush_id_q    <= flush_id_d;
            flush_ex_q    <= flush_ex_d;
            inflight_q    <= inflight_d;
            discard_q     <= discard_d;
        end
    end

`ifdef REDIRECT_STATS_EN
    logic [31:0] redirect_cnt_q;

    // Count accepted redirects, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            redirect_cnt_q <= 32'd0;
        end else if (handshake) begin
            redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
`else
    assign redirect_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_redirect_ctrl
// Description : Directed self-checking bench for redirect_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_redirect_ctrl;

    logic        clk;
    logic        resetn;
    logic        wr_jmp_en;
    logic [31:0] wr_jmp_pc;
    logic        ex_jmp_en;
    logic [31:0] ex_jmp_pc;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic        fetch_req_fire;
    logic        fetch_resp_fire;
    logic        fetch_hold;
    logic        discard_resp;
    logic        flush_if;
    logic        flush_id;
    logic        flush_ex;
    logic [31:0] redirect_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    redirect_ctrl #(.MAX_INFLIGHT(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .wr_jmp_en       (wr_jmp_en),
        .wr_jmp_pc       (wr_jmp_pc),
        .ex_jmp_en       (ex_jmp_en),
        .ex_jmp_pc       (ex_jmp_pc),
        .redir_valid     (redir_valid),
        .redir_pc        (redir_pc),
        .redir_ready     (redir_ready),
        .fetch_req_fire  (fetch_req_fire),
        .fetch_resp_fire (fetch_resp_fire),
        .fetch_hold      (fetch_hold),
        .discard_resp    (discard_resp),
        .flush_if        (flush_if),
        .flush_id        (flush_id),
        .flush_ex        (flush_ex),
        .redirect_cnt    (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All outputs packed into one vector: {valid,hold,discard,fif,fid,fex}
    function automatic logic [5:0] flags();
        return {redir_valid, fetch_hold, discard_resp, flush_if, flush_id, flush_ex};
    endfunction

    initial begin
        resetn = 1'b0; wr_jmp_en = 1'b0; wr_jmp_pc = 32'd0; ex_jmp_en = 1'b0;
        ex_jmp_pc = 32'd0; redir_ready = 1'b0; fetch_req_fire = 1'b0; fetch_resp_fire = 1'b0;

        // ---------------- reset state
        tick(); tick();
        chk("reset_flags", 32'(flags()), 32'h0);
        chk("reset_pc", redir_pc, 32'h0);
        chk("reset_cnt", redirect_cnt, 32'h0);
        resetn = 1'b1;
        tick();

        // ---------------- wr beats ex in the same cycle
        wr_jmp_en = 1'b1; wr_jmp_pc = 32'hBFC00380;
        ex_jmp_en = 1'b1; ex_jmp_pc = 32'h80001000;
        tick();
        wr_jmp_en = 1'b0; ex_jmp_en = 1'b0;
        chk("arb_pc", redir_pc, 32'hBFC00380);
        chk("arb_flags", 32'(flags()), 32'b110_111);
        tick();
        chk("arb_flush_once", 32'(flags()), 32'b110_000);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        chk("arb_hs_idle", 32'(flags()), 32'b000_000);

        // ---------------- ex redirect held 3 cycles, no flush_ex
        ex_jmp_en = 1'b1; ex_jmp_pc = 32'h80000020;
        tick();
        ex_jmp_en = 1'b0;
        chk("ex_flags", 32'(flags()), 32'b110_110);
        chk("ex_pc", redir_pc, 32'h80000020);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ex_hold_flags", 32'(flags()), 32'b110_000);
            chk("ex_hold_pc", redir_pc, 32'h80000020);
        end
        // ex request in HOLD is ignored
        ex_jmp_en = 1'b1; ex_jmp_pc = 32'h12345678;
        tick();
        ex_jmp_en = 1'b0;
        chk("hold_ex_ignored_pc", redir_pc, 32'h80000020);
        chk("hold_ex_ignored_flags", 32'(flags()), 32'b110_000);
        // wr request in HOLD overrides
        wr_jmp_en = 1'b1; wr_jmp_pc = 32'h80000180;
        tick();
        wr_jmp_en = 1'b0;
        chk("hold_wr_pc", redir_pc, 32'h80000180);
        chk("hold_wr_flags", 32'(flags()), 32'b110_111);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        chk("hold_wr_hs", 32'(flags()), 32'b000_000);

        // ---------------- inflight=2 at handshake, no response
        fetch_req_fire = 1'b1;
        tick(); tick();
        fetch_req_fire = 1'b0;
        ex_jmp_en = 1'b1; ex_jmp_pc = 32'h80000400;
        tick();
        ex_jmp_en = 1'b0;
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        chk("drain_entered", 32'(flags()), 32'b010_000);
        fetch_resp_fire = 1'b1;
        #1 chk("drain_resp1", 32'(discard_resp), 32'd1);
        tick();
        chk("drain_hold_after1", 32'(fetch_hold), 32'd1);
        chk("drain_resp2", 32'(discard_resp), 32'd1);
        tick();
        chk("drain_idle_after2", 32'(fetch_hold), 32'd0);
        chk("drain_resp3", 32'(discard_resp), 32'd0);
        tick();
        fetch_resp_fire = 1'b0;

        // ---------------- saturation at 4 and resp on handshake cycle (load 3)
        fetch_req_fire = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        fetch_req_fire = 1'b0;
        ex_jmp_en = 1'b1; ex_jmp_pc = 32'h80000500;
        tick();
        ex_jmp_en = 1'b0;
        redir_ready = 1'b1; fetch_resp_fire = 1'b1;
        #1 chk("sat_hs_resp_not_discarded", 32'(discard_resp), 32'd0);
        tick();
        redir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("sat_discard", 32'(discard_resp), 32'd1);
            tick();
        end
        chk("sat_idle", 32'(fetch_hold), 32'd0);
        chk("sat_no_discard", 32'(discard_resp), 32'd0);
        tick();
        fetch_resp_fire = 1'b0;

        // ---------------- reset during DRAIN with count 2
        fetch_req_fire = 1'b1;
        tick(); tick();
        fetch_req_fire = 1'b0;
        wr_jmp_en = 1'b1; wr_jmp_pc = 32'h80000600;
        tick();
        wr_jmp_en = 1'b0;
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        chk("rst_drain_pre", 32'(fetch_hold), 32'd1);
        resetn = 1'b0;
        tick();
        chk("rst_drain_flags", 32'(flags()), 32'h0);
        chk("rst_drain_pc", redir_pc, 32'h0);
        chk("rst_drain_cnt", redirect_cnt, 32'h0);
        resetn = 1'b1;
        fetch_resp_fire = 1'b1;
        #1 chk("rst_resp_kept", 32'(discard_resp), 32'd0);
        tick();
        chk("rst_resp_kept2", 32'(discard_resp), 32'd0);
        fetch_resp_fire = 1'b0;
        tick();

        // ---------------- 5 handshakes
        for (int i = 0; i < 5; i++) begin
            ex_jmp_en = 1'b1; ex_jmp_pc = 32'h80000700 + 32'(i);
            tick();
            ex_jmp_en = 1'b0; redir_ready = 1'b1;
            tick();
            redir_ready = 1'b0;
        end
`ifdef REDIRECT_STATS_EN
        chk("stats_cnt5", redirect_cnt, 32'd5);
`else
        chk("stats_cnt0", redirect_cnt, 32'd0);
`endif

        // ---------------- handshake coincides with new wr request
        ex_jmp_en = 1'b1; ex_jmp_pc = 32'h80000800;
        tick();
        ex_jmp_en = 1'b0;
        redir_ready = 1'b1; wr_jmp_en = 1'b1; wr_jmp_pc = 32'h80000900;
        tick();
        redir_ready = 1'b0; wr_jmp_en = 1'b0;
        chk("hs_wr_pc", redir_pc, 32'h80000900);
        chk("hs_wr_flags", 32'(flags()), 32'b110_111);
`ifdef REDIRECT_STATS_EN
        chk("hs_wr_cnt", redirect_cnt, 32'd6);
`else
        chk("hs_wr_cnt", redirect_cnt, 32'd0);
`endif
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        chk("hs_wr_done", 32'(flags()), 32'b000_000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/redirect_ctrl.md
REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, meaning the maximum number of outstanding instruction-fetch requests tracked.
REQ-002 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- wr_jmp_en  in  1  redirect request from the write stage (exception/ERET/MTC0).
- wr_jmp_pc  in  32  write-stage target PC.
- ex_jmp_en  in  1  redirect request from the execute stage (branch/jump).
- ex_jmp_pc  in  32  execute-stage target PC.
- redir_valid  out  1  redirect offered to fetch.
- redir_pc  out  32  redirect target.
- redir_ready  in  1  fetch accepts redirect.
- fetch_req_fire  in  1  fetch issued a bus request this cycle.
- fetch_resp_fire  in  1  fetch received a bus response this cycle.
- fetch_hold  out  1  fetch SHALL NOT issue requests while high.
- discard_resp  out  1  current response is stale and SHALL be dropped.
- flush_if, flush_id, flush_ex  out  1 each  one-cycle pipeline flush pulses.
- redirect_cnt  out  32  count of accepted redirects (see Configuration).

Function
REQ-003 SHALL implement states IDLE, HOLD and DRAIN.
REQ-004 Arbitration: wr_jmp_en SHALL win over ex_jmp_en in the same cycle; the ex request is then dropped.
REQ-005 A request sampled in cycle N SHALL drive redir_valid=1 and redir_pc=target in cycle N+1, with state HOLD.
REQ-006 Flush outputs SHALL be registered and pulse in cycle N+1 for exactly one cycle: flush_if and flush_id for any source; flush_ex only for a wr source.
REQ-007 In HOLD, a new wr request SHALL overwrite redir_pc and re-pulse the flushes; a new ex request SHALL be ignored.
REQ-008 redir_valid and redir_pc SHALL hold stable in HOLD until redir_valid && redir_ready.
REQ-009 The inflight counter SHALL be clog2(MAX_INFLIGHT+1) bits wide:
- +1 on req fire alone; -1 on resp fire alone; unchanged on both.
- SHALL saturate at MAX_INFLIGHT and at 0.
REQ-010 On the redirect handshake, the discard counter SHALL load inflight minus (1 if fetch_resp_fire that cycle), and inflight SHALL track normally.
REQ-011 On the handshake, next state SHALL be DRAIN if the loaded discard count is nonzero, otherwise IDLE.
REQ-012 discard_resp SHALL equal fetch_resp_fire && (discard counter != 0), combinationally; each discarded response SHALL decrement the counter.
REQ-013 DRAIN SHALL go to IDLE in the cycle the counter reaches 0; a wr or ex request in DRAIN SHALL go to HOLD while the count continues.
REQ-014 fetch_hold SHALL be 1 in HOLD and DRAIN, and 0 in IDLE.
REQ-015 A handshake in the same cycle as a new wr request SHALL complete; the new request SHALL then be presented per REQ-005.

Reset
REQ-016 With resetn=0 at a rising edge, the following SHALL be cleared: state=IDLE, redir_valid=0, redir_pc=0, all flushes=0, inflight=0, discard counter=0, redirect_cnt=0.
REQ-017 Reset mid-HOLD or mid-DRAIN SHALL abandon the pending redirect without a handshake.

Configuration
REQ-018 Macro REDIRECT_STATS_EN:
- When defined, redirect_cnt SHALL increment by 1 per handshake, wrapping modulo 2^32.
- When undefined, redirect_cnt SHALL be constant 0 and no counter logic SHALL be generated.

Verification
REQ-019 The bench SHALL cover these scenarios:
- wr_jmp_en=1, wr_jmp_pc=0xBFC00380, ex_jmp_en=1, ex_jmp_pc=0x80001000 in cycle N -> cycle N+1: redir_pc=0xBFC00380; flush_if, flush_id and flush_ex each pulse once.
- ex_jmp_pc=0x80000020 with redir_ready low for 3 cycles -> redir_valid and redir_pc stable 3 cycles; flush_ex never asserted.
- Inflight=2 at handshake with no response that cycle -> next 2 responses have discard_resp=1, third has discard_resp=0; state returns to IDLE after the second.
- In HOLD with ex target, wr_jmp_pc=0x80000180 arrives -> redir_pc becomes 0x80000180 next cycle; flushes re-pulse.
- resetn=0 during DRAIN with discard count 2 -> all outputs 0, state IDLE, following responses not discarded.
- REDIRECT_STATS_EN defined, 5 handshakes -> redirect_cnt=5; undefined -> redirect_cnt=0.
